// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
//
// Purpose:
//    Operand-forwarding and load-use hazard detection for the 5-stage RV32I
//    pipeline. The unit keeps its own shadow copy of the destination/control
//    bits of the instructions sitting in EX, MEM and WB. It advances those
//    copies in lock-step with the real pipeline registers, so it needs nothing
//    from the datapath except the decoded ID fields and the flush strobe.
//
//    The forwarding selects are registered. They are computed while the
//    consumer is in ID and are presented while that consumer is in EX.
//
//    Select encoding (ex_fwd_a / ex_fwd_b):
//       00 = register file
//       01 = MEM/WB result (MEM hazard)
//       10 = EX/MEM result (EX hazard)
//       11 = never driven (fourth mux input reserved)
//
// Ports:
//    clk          in   core clock, rising edge
//    rst          in   synchronous reset, active-high
//    id_valid     in   ID stage holds a real instruction
//    id_rs1       in   source register 1 of the ID instruction
//    id_rs2       in   source register 2 of the ID instruction
//    id_use_rs1   in   ID instruction reads rs1
//    id_use_rs2   in   ID instruction reads rs2
//    id_rd        in   destination register of the ID instruction
//    id_regwrite  in   ID instruction writes rd
//    id_memread   in   ID instruction is a load
//    flush        in   taken branch/jump: kill the ID and EX instructions
//    ex_fwd_a     out  forwarding select, operand A of the EX instruction
//    ex_fwd_b     out  forwarding select, operand B / store data of EX
//    stall        out  load-use stall (combinational)
//    stall_count  out  stall cycles since reset
//
// Build option:
//    HAZ_STALL_CNT_EN - when defined, stall_count is a free-running counter
//                       of stall cycles that wraps at all-ones. When it is
//                       undefined, stall_count is tied to zero and no counter
//                       is built.
// -----------------------------------------------------------------------------
module fwd_hazard_unit #(
   parameter int REG_AW   = 5,
   parameter int STALL_CW = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                id_valid,
   input  logic [REG_AW-1:0]   id_rs1,
   input  logic [REG_AW-1:0]   id_rs2,
   input  logic                id_use_rs1,
   input  logic                id_use_rs2,
   input  logic [REG_AW-1:0]   id_rd,
   input  logic                id_regwrite,
   input  logic                id_memread,
   input  logic                flush,
   output logic [1:0]          ex_fwd_a,
   output logic [1:0]          ex_fwd_b,
   output logic                stall,
   output logic [STALL_CW-1:0] stall_count
);

   // Shadow of one pipeline stage. A bubble is the all-zero value.
   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              regwrite;
      logic              memread;
   } shadow_t;

   localparam shadow_t BUBBLE = '0;

   shadow_t r_ex;
   shadow_t r_mem;
   shadow_t r_wb;

   logic [1:0] r_fwd_a;
   logic [1:0] r_fwd_b;

   // ID fields packed into shadow form. An invalid ID slot enters EX as a
   // clean bubble, so every field of an invalid stage is always zero.
   shadow_t w_id_shadow;

   assign w_id_shadow = id_valid ? '{valid:    1'b1,
                                     rd:       id_rd,
                                     regwrite: id_regwrite,
                                     memread:  id_memread}
                                 : BUBBLE;

   // Per-operand hazard detection. Operand 0 is rs1/A and operand 1 is rs2/B.
   logic [REG_AW-1:0] w_src      [2];
   logic              w_use      [2];
   logic [1:0]        w_ex_hit;
   logic [1:0]        w_mem_hit;
   logic [1:0]        w_fwd_next [2];

   assign w_src[0] = id_rs1;
   assign w_src[1] = id_rs2;
   assign w_use[0] = id_use_rs1;
   assign w_use[1] = id_use_rs2;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_opnd
         // A stage "writes r" only for a live, register-writing instruction
         // whose rd is r and is not x0. x0 must never be forwarded.
         assign w_ex_hit[gi]  = id_valid & w_use[gi]
                              & r_ex.valid & r_ex.regwrite
                              & (r_ex.rd == w_src[gi])
                              & (w_src[gi] != '0);

         assign w_mem_hit[gi] = id_valid & w_use[gi]
                              & r_mem.valid & r_mem.regwrite
                              & (r_mem.rd == w_src[gi])
                              & (w_src[gi] != '0);

         // The most recent producer wins. After the edge, the pre-edge EX
         // instruction sits in EX/MEM and the pre-edge MEM instruction sits
         // in MEM/WB.
         assign w_fwd_next[gi] = w_ex_hit[gi]  ? 2'b10 :
                                 w_mem_hit[gi] ? 2'b01 : 2'b00;
      end
   endgenerate

   // Load-use: the EX instruction is a load feeding a used ID operand. The
   // ID instruction cannot be served by forwarding because the data arrives
   // only at the end of MEM. A flush kills the consumer, so no stall is raised.
   assign stall = (w_ex_hit[0] | w_ex_hit[1]) & r_ex.memread & ~flush;

   // Shadow pipeline and registered selects.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ex    <= BUBBLE;
         r_mem   <= BUBBLE;
         r_wb    <= BUBBLE;
         r_fwd_a <= 2'b00;
         r_fwd_b <= 2'b00;
      end else if (flush) begin
         // The ID and EX instructions are both wrong-path. The one leaving EX
         // must not reach MEM, or it would still be seen as a producer.
         r_ex    <= BUBBLE;
         r_mem   <= BUBBLE;
         r_wb    <= r_mem;
         r_fwd_a <= 2'b00;
         r_fwd_b <= 2'b00;
      end else if (stall) begin
         // ID is held. A bubble goes into EX while the load moves on to MEM.
         r_ex    <= BUBBLE;
         r_mem   <= r_ex;
         r_wb    <= r_mem;
         r_fwd_a <= 2'b00;
         r_fwd_b <= 2'b00;
      end else begin
         r_ex    <= w_id_shadow;
         r_mem   <= r_ex;
         r_wb    <= r_mem;
         r_fwd_a <= w_fwd_next[0];
         r_fwd_b <= w_fwd_next[1];
      end
   end

   // Bubbles and invalid ID slots are all-zero. If a dead WB entry carried
   // stale control bits, the shadow advance logic has been broken.
   always_ff @(posedge clk) begin
      if (!rst && !r_wb.valid) begin
         assert (r_wb.rd == '0 && !r_wb.regwrite && !r_wb.memread);
      end
   end

   assign ex_fwd_a = r_fwd_a;
   assign ex_fwd_b = r_fwd_b;

`ifdef HAZ_STALL_CNT_EN
   logic [STALL_CW-1:0] r_stall_count;

   // Counts every cycle in which a stall is raised. Wraps naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_count <= '0;
      end else if (stall) begin
         r_stall_count <= r_stall_count + STALL_CW'(1);
      end
   end

   assign stall_count = r_stall_count;
`else
   assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

   localparam int AW = 5;
   localparam int CW = 32;
`ifdef HAZ_STALL_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          id_valid = 1'b0;
   logic [AW-1:0] id_rs1 = '0;
   logic [AW-1:0] id_rs2 = '0;
   logic          id_use_rs1 = 1'b0;
   logic          id_use_rs2 = 1'b0;
   logic [AW-1:0] id_rd = '0;
   logic          id_regwrite = 1'b0;
   logic          id_memread = 1'b0;
   logic          flush = 1'b0;
   logic [1:0]    ex_fwd_a;
   logic [1:0]    ex_fwd_b;
   logic          stall;
   logic [CW-1:0] stall_count;

   fwd_hazard_unit #(.REG_AW(AW), .STALL_CW(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .id_valid    (id_valid),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_use_rs1  (id_use_rs1),
      .id_use_rs2  (id_use_rs2),
      .id_rd       (id_rd),
      .id_regwrite (id_regwrite),
      .id_memread  (id_memread),
      .flush       (flush),
      .ex_fwd_a    (ex_fwd_a),
      .ex_fwd_b    (ex_fwd_b),
      .stall       (stall),
      .stall_count (stall_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          v;
      logic [AW-1:0] rs1;
      logic [AW-1:0] rs2;
      logic          u1;
      logic          u2;
      logic [AW-1:0] rd;
      logic          rw;
      logic          mr;
   } ins_t;

   typedef struct {
      logic          chk;
      logic [1:0]    a;
      logic [1:0]    b;
      logic          s;
      logic [CW-1:0] cnt;
      string         nm;
   } exp_t;

   exp_t    sb_q[$];
   int      n_vec = 0;
   int      n_err = 0;
   int      n_cyc = 0;
   logic [CW-1:0] exp_cnt = '0;

   function automatic ins_t nop();
      return '0;
   endfunction

   // R-type / store / branch: both sources read
   function automatic ins_t rr(input int rd, input int rs1, input int rs2);
      ins_t t = '0;
      t.v = 1'b1; t.rs1 = AW'(rs1); t.rs2 = AW'(rs2);
      t.u1 = 1'b1; t.u2 = 1'b1; t.rd = AW'(rd); t.rw = 1'b1;
      return t;
   endfunction

   // I-type ALU: only rs1 read, rs2 field may hold anything
   function automatic ins_t ri(input int rd, input int rs1, input int rs2f);
      ins_t t = '0;
      t.v = 1'b1; t.rs1 = AW'(rs1); t.rs2 = AW'(rs2f);
      t.u1 = 1'b1; t.rd = AW'(rd); t.rw = 1'b1;
      return t;
   endfunction

   function automatic ins_t lw(input int rd, input int rs1);
      ins_t t = ri(rd, rs1, 0);
      t.mr = 1'b1;
      return t;
   endfunction

   // One pipeline cycle: drive ID inputs, queue the outputs expected during
   // this cycle (selects of the EX instruction, stall of the ID instruction).
   task automatic cyc(input ins_t ins, input logic fl, input logic r,
                      input logic [1:0] ea, input logic [1:0] eb,
                      input logic es, input logic chk, input string nm);
      exp_t e;
      rst         = r;
      id_valid    = ins.v;
      id_rs1      = ins.rs1;
      id_rs2      = ins.rs2;
      id_use_rs1  = ins.u1;
      id_use_rs2  = ins.u2;
      id_rd       = ins.rd;
      id_regwrite = ins.rw;
      id_memread  = ins.mr;
      flush       = fl;
      e.chk = chk; e.a = ea; e.b = eb; e.s = es;
      e.cnt = CNT_EN ? exp_cnt : '0;
      e.nm  = nm;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (r) exp_cnt = '0;
      else if (es) exp_cnt = exp_cnt + 1;
   endtask

   function automatic ins_t rnd_ins();
      ins_t t;
      t = ins_t'($urandom);
      return t;
   endfunction

   // Monitor: one expected entry per cycle, compared mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.chk) begin
               n_vec++;
               if (ex_fwd_a !== e.a) begin
                  n_err++;
                  $display("FAIL %s fwd_a got %b want %b", e.nm, ex_fwd_a, e.a);
               end
               if (ex_fwd_b !== e.b) begin
                  n_err++;
                  $display("FAIL %s fwd_b got %b want %b", e.nm, ex_fwd_b, e.b);
               end
               if (stall !== e.s) begin
                  n_err++;
                  $display("FAIL %s stall got %b want %b", e.nm, stall, e.s);
               end
               if (stall_count !== e.cnt) begin
                  n_err++;
                  $display("FAIL %s stall_count got %0d want %0d", e.nm, stall_count, e.cnt);
               end
               $display("vec %0d %-12s a=%b b=%b stall=%b cnt=%0d", n_vec, e.nm,
                        ex_fwd_a, ex_fwd_b, stall, stall_count);
            end
         end
      end
   end

   initial begin
      @(posedge clk);
      #1;
      // reset with random inputs
      cyc(rnd_ins(), 1'($urandom), 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "rst1");
      cyc(rnd_ins(), 1'($urandom), 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, "rst2");
      cyc(nop(),        1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "post_rst");
      // EX hazard on rs1
      cyc(rr(5, 1, 2),  1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "add_x5");
      cyc(rr(6, 5, 7),  1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "sub_id");
      cyc(nop(),        1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b1, "sub_ex");
      cyc(nop(),        1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "idle1");
      // MEM hazard on rs2
      cyc(rr(5, 1, 2),  1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "add_x5b");
      cyc(nop(),        1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "gap");
      cyc(rr(8, 9, 5),  1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "or_id");
      cyc(nop(),        1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b1, "or_ex");
      // EX beats MEM
      cyc(rr(5, 1, 2),  1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "add_x5c");
      cyc(rr(5, 1, 2),  1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "add_x5d");
      cyc(rr(1, 5, 5),  1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "xor_id");
      cyc(nop(),        1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 1'b1, "xor_ex");
      cyc(nop(),        1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "idle2");
      // load-use on rs1
      cyc(lw(7, 1),     1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "lw_x7");
      cyc(rr(3, 7, 2),  1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, "lu_stall");
      cyc(rr(3, 7, 2),  1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "lu_bubble");
      cyc(nop(),        1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, "lu_ex");
      cyc(nop(),        1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "idle3");
      // x0 never forwarded, unused rs2 ignored
      cyc(ri(0, 0, 0),  1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "addi_x0");
      cyc(rr(4, 0, 0),  1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "add_x0x0");
      cyc(ri(10, 11, 4),1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "x0_ex");
      cyc(nop(),        1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "no_use_rs2");
      cyc(nop(),        1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "idle4");
      // flush kills the producer in EX and the ID consumer
      cyc(rr(5, 1, 2),  1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "add_x5e");
      cyc(rr(12, 5, 5), 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "flush");
      cyc(rr(6, 5, 5),  1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "post_flush");
      cyc(nop(),        1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "flush_cons");
      // flush suppresses load-use stall
      cyc(lw(7, 1),     1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "lw_x7b");
      cyc(rr(3, 7, 2),  1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "lu_flush");
      cyc(nop(),        1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "lu_fl_after");
      cyc(nop(),        1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "idle5");
      // reset mid-stream
      cyc(rr(5, 1, 2),  1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "add_x5f");
      cyc(rr(6, 5, 7),  1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, "mid_rst");
      cyc(rr(8, 9, 5),  1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "after_rst");
      cyc(nop(),        1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "rst_cons");
      cyc(nop(),        1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "idle6");
      // load-use on rs2 after reset, counter restarts
      cyc(lw(7, 1),     1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "lw_x7c");
      cyc(rr(3, 2, 7),  1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, "lu2_stall");
      cyc(rr(3, 2, 7),  1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "lu2_bubble");
      cyc(nop(),        1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b1, "lu2_ex");
      cyc(nop(),        1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "idle7");
      // bounded drain of the scoreboard
      for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
      #2;
      if (sb_q.size() > 0) begin
         n_err++;
         $display("FAIL drain queue_left got %0d want 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
